register_file_vec_sb: RTL and testbench



---
 rtl/vrf_pkg.sv | 20 ++
 rtl/vrf_scoreboard.sv | 37 +++
 rtl/register_file_vec_sb.sv | 139 +++++++++++++
 tb/tb_register_file_vec_sb.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_pkg.sv
// Shared types and defaults for the vector register file.
// Module-level parameters override the defaults; the typedefs describe the default shape.
package vrf_pkg;

  localparam int VRF_NREGS  = 8;
  localparam int VRF_LANES  = 8;
  localparam int VRF_LANE_W = 32;
  localparam int VREG_AW    = $clog2(VRF_NREGS);

  typedef logic [VRF_LANE_W-1:0] lane_t;
  typedef lane_t [VRF_LANES-1:0] vreg_t;
  typedef logic [VREG_AW-1:0]    vaddr_t;

  // Clear sweep runs after every reset before the array accepts traffic.
  typedef enum logic {
    INIT_SWEEP = 1'b0,
    READY      = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/vrf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
// A same-edge issue and writeback to one register leaves it pending.
module vrf_scoreboard #(
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          busy1,
  output logic          busy2
);

  logic [NREGS-1:0] sb;
  logic [NREGS-1:0] sb_next;

  // Clear first so a same-edge set to the same register wins.
  always_comb begin
    sb_next = sb;
    if (clr_en) sb_next[clr_addr] = 1'b0;
    if (set_en) sb_next[set_addr] = 1'b1;
  end

  always_ff @(negedge clk) begin
    if (reset) sb <= '0;
    else       sb <= sb_next;
  end

  assign busy1 = sb[ra1];
  assign busy2 = sb[ra2];

endmodule

// File: rtl/register_file_vec_sb.sv
// Vector register file: two combinational reads, one lane-masked write, pending-write
// scoreboard and a post-reset clear sweep. All state updates on the falling edge.
module register_file_vec_sb
  import vrf_pkg::*;
#(
  parameter  int NREGS      = VRF_NREGS,
  parameter  int LANES      = VRF_LANES,
  parameter  int LANE_W     = VRF_LANE_W,
  parameter  int ALIAS_LAST = 1,
  localparam int AW         = $clog2(NREGS),
  localparam int DW         = LANES * LANE_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          busy1,
  output logic          busy2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [LANES-1:0] wmask,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic [31:0]   pc_val,
  output logic          init_busy
);

  localparam logic [AW-1:0] LAST_REG  = AW'(NREGS - 1);
  localparam logic          ALIAS_ON  = (ALIAS_LAST != 0);

  sweep_state_t  state;
  sweep_state_t  state_next;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_next;
  logic          ready;

  logic [DW-1:0] rf [NREGS];

  assign ready     = (state == READY);
  assign init_busy = ~ready;

  // Sweep FSM: one register cleared per edge, ready after the last one.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      INIT_SWEEP: begin
        ptr_next = ptr + AW'(1);
        if (ptr == LAST_REG) state_next = READY;
      end
      READY:   state_next = READY;
      default: state_next = INIT_SWEEP;
    endcase
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state <= INIT_SWEEP;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Single write port shared by the sweep and writeback so the array maps to one-port-write RAM.
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [LANES-1:0] wr_lane_en;
  logic [DW-1:0]    wr_data;

  always_comb begin
    wr_en      = 1'b0;
    wr_addr    = wa;
    wr_lane_en = wmask;
    wr_data    = wd;
    if (!reset) begin
      if (!ready) begin
        wr_en      = 1'b1;
        wr_addr    = ptr;
        wr_lane_en = '1;
        wr_data    = '0;
      end else if (we) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_lane_en[i]) rf[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
      end
    end
  end

  logic sb_busy1;
  logic sb_busy2;

  vrf_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .clr_en   (we & ready),
    .clr_addr (wa),
    .set_en   (issue_valid & ready),
    .set_addr (issue_rd),
    .ra1      (ra1),
    .ra2      (ra2),
    .busy1    (sb_busy1),
    .busy2    (sb_busy2)
  );

  logic          alias1;
  logic          alias2;
  logic [DW-1:0] pc_ext;

  assign alias1 = ALIAS_ON && (ra1 == LAST_REG);
  assign alias2 = ALIAS_ON && (ra2 == LAST_REG);
  assign pc_ext = DW'(pc_val);

  // No write-to-read bypass: the falling-edge write lands before second-half reads.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ready) begin
      rd1 = alias1 ? pc_ext : rf[ra1];
      rd2 = alias2 ? pc_ext : rf[ra2];
    end
  end

  assign busy1 = ready & sb_busy1 & ~alias1;
  assign busy2 = ready & sb_busy2 & ~alias2;

endmodule

// File: tb/tb_register_file_vec_sb.sv
// Directed bench for register_file_vec_sb: sweep timing, masked writes, aliasing,
// scoreboard priority and reset/sweep interaction.
module tb_register_file_vec_sb;

  logic         clk;
  logic         reset;
  logic [2:0]   ra1;
  logic [2:0]   ra2;
  logic [255:0] rd1;
  logic [255:0] rd2;
  logic         busy1;
  logic         busy2;
  logic         we;
  logic [2:0]   wa;
  logic [255:0] wd;
  logic [7:0]   wmask;
  logic         issue_valid;
  logic [2:0]   issue_rd;
  logic [31:0]  pc_val;
  logic         init_busy;

  int checks;
  int errors;

  register_file_vec_sb dut (
    .clk         (clk),
    .reset       (reset),
    .ra1         (ra1),
    .ra2         (ra2),
    .rd1         (rd1),
    .rd2         (rd2),
    .busy1       (busy1),
    .busy2       (busy2),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .wmask       (wmask),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .pc_val      (pc_val),
    .init_busy   (init_busy)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Outputs are sampled 1 time unit after the active (falling) edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we          = 1'b0;
    wa          = '0;
    wd          = '0;
    wmask       = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic write_reg(input logic [2:0] addr, input logic [255:0] data, input logic [7:0] mask);
    we    = 1'b1;
    wa    = addr;
    wd    = data;
    wmask = mask;
    tick();
    we    = 1'b0;
    wmask = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ra1 = 3'd0;
    ra2 = 3'd7;
    #1;
    checks++;
    if (init_busy !== 1'b1) begin
      errors++; $display("FAIL reset_init_busy: got %b want 1", init_busy);
    end
    checks++;
    if (rd1 !== '0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL reset_reads: rd1=%h busy1=%b busy2=%b want 0", rd1, busy1, busy2);
    end
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (init_busy !== (e < 8)) begin
        errors++; $display("FAIL sweep_len edge %0d: init_busy=%b want %b", e, init_busy, (e < 8));
      end
    end
    for (int r = 0; r < 7; r++) begin
      ra1 = 3'(r);
      #1;
      checks++;
      if (rd1 !== '0 || busy1 !== 1'b0) begin
        errors++; $display("FAIL post_sweep_zero r%0d: rd1=%h busy1=%b want 0", r, rd1, busy1);
      end
    end
    pc_val = 32'h0000_0040;
    ra1 = 3'd7;
    #1;
    checks++;
    if (rd1 !== 256'h40) begin
      errors++; $display("FAIL alias_read: rd1=%h want %h", rd1, 256'h40);
    end
  endtask

  task automatic test_write_mask();
    logic [255:0] first;
    logic [255:0] expv;
    for (int i = 0; i < 8; i++) first[i*32 +: 32] = 32'h1111_1111 * i;
    write_reg(3'd3, first, 8'hFF);
    ra1 = 3'd3;
    ra2 = 3'd3;
    #1;
    checks++;
    if (rd1 !== first) begin
      errors++; $display("FAIL write_full: rd1=%h want %h", rd1, first);
    end
    write_reg(3'd3, {8{32'hDEAD_BEEF}}, 8'b0000_0101);
    expv = first;
    expv[0*32 +: 32] = 32'hDEAD_BEEF;
    expv[2*32 +: 32] = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (rd1 !== expv) begin
      errors++; $display("FAIL write_masked rd1: got %h want %h", rd1, expv);
    end
    checks++;
    if (rd2 !== expv) begin
      errors++; $display("FAIL write_masked rd2: got %h want %h", rd2, expv);
    end
    // Register 7 is written but still reads as pc_val.
    write_reg(3'd7, {8{32'h5A5A_5A5A}}, 8'hFF);
    pc_val = 32'h0000_1234;
    ra2 = 3'd7;
    #1;
    checks++;
    if (rd2 !== 256'h1234) begin
      errors++; $display("FAIL alias_after_write: rd2=%h want %h", rd2, 256'h1234);
    end
  endtask

  task automatic test_scoreboard();
    ra2 = 3'd5;
    issue_valid = 1'b1;
    issue_rd = 3'd5;
    #1;
    checks++;
    if (busy2 !== 1'b0) begin
      errors++; $display("FAIL sb_before_issue: busy2=%b want 0", busy2);
    end
    tick();
    issue_valid = 1'b0;
    checks++;
    if (busy2 !== 1'b1) begin
      errors++; $display("FAIL sb_issue: busy2=%b want 1", busy2);
    end
    write_reg(3'd5, {8{32'h0000_0005}}, 8'hFF);
    checks++;
    if (busy2 !== 1'b0) begin
      errors++; $display("FAIL sb_clear: busy2=%b want 0", busy2);
    end
    issue_valid = 1'b1;
    issue_rd = 3'd5;
    tick();
    we = 1'b1;
    wa = 3'd5;
    wmask = 8'hFF;
    tick();
    idle_inputs();
    checks++;
    if (busy2 !== 1'b1) begin
      errors++; $display("FAIL sb_same_edge: busy2=%b want 1", busy2);
    end
    issue_valid = 1'b1;
    issue_rd = 3'd5;
    tick();
    issue_valid = 1'b0;
    checks++;
    if (busy2 !== 1'b1) begin
      errors++; $display("FAIL sb_reissue: busy2=%b want 1", busy2);
    end
    write_reg(3'd5, {8{32'h0000_0005}}, 8'hFF);
    checks++;
    if (busy2 !== 1'b0) begin
      errors++; $display("FAIL sb_single_clear: busy2=%b want 0", busy2);
    end
    issue_valid = 1'b1;
    issue_rd = 3'd7;
    ra1 = 3'd7;
    tick();
    issue_valid = 1'b0;
    checks++;
    if (busy1 !== 1'b0) begin
      errors++; $display("FAIL sb_alias_forced0: busy1=%b want 0", busy1);
    end
  endtask

  task automatic test_mask_zero();
    write_reg(3'd2, {8{32'hA5A5_0202}}, 8'hFF);
    issue_valid = 1'b1;
    issue_rd = 3'd2;
    ra1 = 3'd2;
    tick();
    issue_valid = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin
      errors++; $display("FAIL mask0_pending: busy1=%b want 1", busy1);
    end
    write_reg(3'd2, {8{32'hFFFF_FFFF}}, 8'h00);
    checks++;
    if (rd1 !== {8{32'hA5A5_0202}}) begin
      errors++; $display("FAIL mask0_data: rd1=%h want %h", rd1, {8{32'hA5A5_0202}});
    end
    checks++;
    if (busy1 !== 1'b0) begin
      errors++; $display("FAIL mask0_busy: busy1=%b want 0", busy1);
    end
  endtask

  task automatic test_sweep_restart();
    write_reg(3'd6, {8{32'hCAFE_0006}}, 8'hFF);
    issue_valid = 1'b1;
    issue_rd = 3'd4;
    ra1 = 3'd6;
    tick();
    issue_valid = 1'b0;
    checks++;
    if (rd1 !== {8{32'hCAFE_0006}}) begin
      errors++; $display("FAIL restart_stale_setup: rd1=%h want %h", rd1, {8{32'hCAFE_0006}});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 0; e < 3; e++) tick();
    checks++;
    if (init_busy !== 1'b1) begin
      errors++; $display("FAIL restart_mid_sweep: init_busy=%b want 1", init_busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (init_busy !== (e < 8)) begin
        errors++; $display("FAIL restart_len edge %0d: init_busy=%b want %b", e, init_busy, (e < 8));
      end
    end
    ra1 = 3'd6;
    #1;
    checks++;
    if (rd1 !== '0) begin
      errors++; $display("FAIL restart_rf6: rd1=%h want 0", rd1);
    end
    for (int r = 0; r < 7; r++) begin
      ra2 = 3'(r);
      #1;
      checks++;
      if (busy2 !== 1'b0) begin
        errors++; $display("FAIL restart_sb r%0d: busy2=%b want 0", r, busy2);
      end
    end
  endtask

  task automatic test_ignore_during_sweep();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    we = 1'b1;
    wa = 3'd1;
    wd = {8{32'h1357_9BDF}};
    wmask = 8'hFF;
    issue_valid = 1'b1;
    issue_rd = 3'd1;
    for (int e = 0; e < 8; e++) tick();
    idle_inputs();
    ra1 = 3'd1;
    #1;
    checks++;
    if (init_busy !== 1'b0) begin
      errors++; $display("FAIL ignore_sweep_done: init_busy=%b want 0", init_busy);
    end
    checks++;
    if (rd1 !== '0) begin
      errors++; $display("FAIL ignore_we: rd1=%h want 0", rd1);
    end
    checks++;
    if (busy1 !== 1'b0) begin
      errors++; $display("FAIL ignore_issue: busy1=%b want 0", busy1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    ra1    = '0;
    ra2    = '0;
    pc_val = '0;
    idle_inputs();
    test_reset();
    test_write_mask();
    test_scoreboard();
    test_mask_zero();
    test_sweep_restart();
    test_ignore_during_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
